// File: rtl/spi_sensor_responder.sv
`timescale 1ns/1ps
// spi_sensor_responder: SPI mode-0 slave emulating an accelerometer register map.
// Latency: sclk/cs_n pin edge -> internal strobe 3 clk; miso updates 1 clk after the falling strobe.
// Backpressure: none; the master owns the bit rate, and clk must be at least 8x sclk.
//
// Ports:
//   clk, rst_n             system clock, async active-low reset
//   sclk, cs_n, mosi       raw SPI inputs from the master (synchronised internally)
//   x_data/y_data/z_data   live sensor samples, captured when a read byte is loaded
//   miso, miso_oe          serial read data and board-level tri-state enable
//   power_ctl, measure     POWER_CTL contents and its measure-mode decode
//   soft_rst               one-clk pulse when 0x52 is written to SOFT_RESET
module spi_sensor_responder #(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    input  logic [7:0] x_data,
    input  logic [7:0] y_data,
    input  logic [7:0] z_data,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] power_ctl,
    output logic       measure,
    output logic       soft_rst
);

    localparam logic [7:0] CMD_WR     = 8'h0A;
    localparam logic [7:0] CMD_RD     = 8'h0B;
    localparam logic [7:0] A_SOFT_RST = 8'h1F;
    localparam logic [7:0] A_PWR_CTL  = 8'h2D;
    localparam logic [7:0] SOFT_KEY   = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE
    } state_t;

    state_t state_q, state_d;

    // Synchronisers: [0],[1] form the 2-flop synchroniser, [2] is the edge-detect delay.
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] addr_q, addr_d;
    logic       cmd_rd_q, cmd_rd_d;
    logic [7:0] power_ctl_q, power_ctl_d;
    logic       soft_rst_q, soft_rst_d;

    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic [7:0] rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[1:0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];

    // mosi and sclk share the same synchroniser depth, so mosi_q[1] is the bit under the rising strobe.
    assign rx_byte   = {rx_shift_q[6:0], mosi_q[1]};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

    // Read map; sensor samples are taken live at tx load time.
    always_comb begin
        rd_data = 8'h00;
        case (addr_q)
            8'h00:     rd_data = DEVID_AD;
            8'h01:     rd_data = DEVID_MST;
            8'h02:     rd_data = PARTID;
            8'h08:     rd_data = x_data;
            8'h09:     rd_data = y_data;
            8'h0A:     rd_data = z_data;
            A_PWR_CTL: rd_data = power_ctl_q;
            default:   rd_data = 8'h00;
        endcase
    end

    // FSM process 1: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM process 2: next state. A cs_n rise beats everything, including a coincident strobe.
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = S_IDLE;
        end else if (cs_fall) begin
            state_d = S_CMD;
        end else begin
            case (state_q)
                S_CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_WR || rx_byte == CMD_RD) state_d = S_ADDR;
                        else                                        state_d = S_IGNORE;
                    end
                end
                S_ADDR: begin
                    if (byte_done) state_d = cmd_rd_q ? S_RDATA : S_WDATA;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // FSM process 3: outputs
    always_comb begin
        miso    = (state_q == S_RDATA) ? tx_shift_q[7] : 1'b0;
        miso_oe = ~cs_q[2];
    end

    // Datapath next-state.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        addr_d      = addr_q;
        cmd_rd_d    = cmd_rd_q;
        power_ctl_d = power_ctl_q;
        soft_rst_d  = 1'b0;

        if (cs_fall) begin
            bit_cnt_d  = 3'd0;
            rx_shift_d = 8'h00;
            tx_shift_d = 8'h00;
        end else if (!cs_rise && state_q != S_IDLE) begin
            if (sclk_rise) begin
                bit_cnt_d  = bit_cnt_q + 3'd1;
                rx_shift_d = rx_byte;
                if (byte_done) begin
                    case (state_q)
                        S_CMD:  cmd_rd_d = (rx_byte == CMD_RD);
                        S_ADDR: addr_d   = rx_byte;
                        S_WDATA: begin
                            if (addr_q == A_PWR_CTL) begin
                                power_ctl_d = rx_byte;
                            end else if (addr_q == A_SOFT_RST && rx_byte == SOFT_KEY) begin
                                power_ctl_d = 8'h00;
                                soft_rst_d  = 1'b1;
                            end
                            addr_d = addr_q + 8'd1;
                        end
                        default: ;
                    endcase
                end
            end
            // The falling edge with the bit counter at 0 opens a new read byte.
            if (sclk_fall && state_q == S_RDATA) begin
                if (bit_cnt_q == 3'd0) begin
                    tx_shift_d = rd_data;
                    addr_d     = addr_q + 8'd1;
                end else begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            addr_q      <= 8'h00;
            cmd_rd_q    <= 1'b0;
            power_ctl_q <= 8'h00;
            soft_rst_q  <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            addr_q      <= addr_d;
            cmd_rd_q    <= cmd_rd_d;
            power_ctl_q <= power_ctl_d;
            soft_rst_q  <= soft_rst_d;
        end
    end

    assign power_ctl = power_ctl_q;
    assign measure   = (power_ctl_q[1:0] == 2'b10);
    assign soft_rst  = soft_rst_q;

endmodule

// File: doc/spi_sensor_responder.md
# spi_sensor_responder

SPI slave that models the accelerometer end of the link driven by the team's SPI master. It receives command/address/data bytes on `mosi`, serves a small register map (device IDs, X/Y/Z samples, POWER_CTL, SOFT_RESET) and returns read data on `miso`. It runs entirely on the system clock and oversamples `sclk`, `cs_n` and `mosi`. It sits in the testbench or sensor-emulation top as the counterpart of the master.

## Interface
- `DEVID_AD`, 8'hAD, value returned at address 0x00
- `DEVID_MST`, 8'h1D, value returned at address 0x01
- `PARTID`, 8'hF2, value returned at address 0x02
- `clk` in 1: system clock (100 MHz); must be ≥ 8× the `sclk` frequency
- `rst_n` in 1: reset, asynchronous, active-low
- `sclk` in 1: SPI clock from the master, asynchronous to `clk`
- `cs_n` in 1: chip select, active-low, asynchronous
- `mosi` in 1: serial data from the master, MSB first
- `x_data`, `y_data`, `z_data` in 8 each: current sensor samples
- `miso` out 1: serial data to the master, MSB first
- `miso_oe` out 1: high while `cs_n` (synchronised) is low; board-level tri-state enable
- `power_ctl` out 8: POWER_CTL register contents
- `measure` out 1: `power_ctl[1:0] == 2'b10`
- `soft_rst` out 1: one-`clk` pulse on a valid soft reset

## Operation
- SPI mode 0: bits sampled on the `sclk` rising edge; `miso` changes on the falling edge. MSB first.
- `sclk`, `cs_n` and `mosi` each pass through a 2-flop synchroniser. Edges are detected on synchronised `sclk` against a third delayed flop.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
  - IDLE → CMD when synchronised `cs_n` falls. Bit counter clears and the rx shift register clears.
  - CMD: after 8 rising edges, byte 0x0A → ADDR (write), 0x0B → ADDR (read), any other value → IGNORE.
  - ADDR: after 8 bits, latch `addr`. Go to WDATA if the command was 0x0A, RDATA if it was 0x0B.
  - WDATA: each completed byte writes `reg[addr]`, then `addr <= addr + 1`.
  - RDATA: on the falling edge that starts each byte, load the tx shift register from `reg[addr]`, then `addr <= addr + 1`. Other falling edges shift left. `miso = tx_shift[7]`.
  - IGNORE: stay until `cs_n` rises.
  - Any state → IDLE when synchronised `cs_n` rises.
- Register map:
  - 0x00/0x01/0x02: parameters, read-only.
  - 0x08/0x09/0x0A: `x_data`/`y_data`/`z_data`, read-only, sampled at tx load time.
  - 0x1F SOFT_RESET: write-only, reads 0x00.
  - 0x2D POWER_CTL: R/W, reset 0x00.
  - All other addresses read 0x00; writes to them are ignored.
- A write of 0x52 to 0x1F clears `power_ctl` to 0x00 and pulses `soft_rst`. Any other value written to 0x1F is ignored.
- `addr` is 8 bits and wraps 0xFF → 0x00 during bursts.
- `miso` is 0 in IDLE, CMD, ADDR, WDATA and IGNORE.

## Timing
- Reset values:
  - FSM in IDLE; `addr`, shift registers and bit counter at 0.
  - `miso`=0, `miso_oe`=0, `power_ctl`=0x00, `measure`=0, `soft_rst`=0.
  - All synchroniser flops reset to idle levels: `sclk`=0, `cs_n`=1, `mosi`=0.
- Edge detect latency: an `sclk` pin edge produces its internal strobe 3 `clk` cycles later. `cs_n` has the same latency.
- Write commit: `power_ctl` updates on the `clk` after the 8th rising-edge strobe of the data byte. `soft_rst` is high in that same cycle, for exactly 1 cycle.
- Read data: `miso` takes the new bit 1 `clk` after the falling-edge strobe, i.e. ≤ 4 `clk` (40 ns) after the pin edge. This is well inside a 100 ns half-period at 5 MHz.
- `cs_n` rising mid-byte aborts the transfer:
  - The partial byte is discarded and no write happens.
  - `miso`/`miso_oe` go to 0 with the FSM's return to IDLE.
- `cs_n` falling while the FSM is not in IDLE (glitch-free re-select): restart in CMD.
- When a falling strobe and `cs_n` rising coincide, `cs_n` wins.
- `rst_n` asserted mid-transfer: all state returns immediately to reset values. The transaction is lost.

## Test plan
- Write 0x0A, 0x2D, 0x02 → `power_ctl`=0x02, `measure`=1, no `soft_rst`.
- Read 0x0B, 0x00, dummy ×3 → `miso` bytes 0xAD, 0x1D, 0xF2 (burst auto-increment).
- `x_data`=0x11, `y_data`=0x22, `z_data`=0x33; read from 0x08 with 3 dummy bytes → 0x11, 0x22, 0x33. With address 0xFF and 2 dummy bytes → 0x00, 0xAD (wrap).
- `power_ctl`=0x02, then write 0x0A, 0x1F, 0x52 → `soft_rst` pulse of 1 cycle, `power_ctl`=0x00. Writing 0x51 instead → no change.
- Abort cases, each leaving `power_ctl` unchanged:
  - Raise `cs_n` after 4 bits of a POWER_CTL data byte → register unchanged.
  - Unknown command 0x55 then 16 clocks → `miso`=0 and no state change.
- Assert `rst_n` low mid-read-burst → all outputs return to reset values within the same cycle. The next full transaction completes correctly.
